bcd_frame_deserializer: RTL and testbench
=========================================

Name: bcd_frame_deserializer

Overview:
- Downstream consumer of the BCD-counter-addressed serial bit stream. Each cycle it receives one data bit plus the 4-bit BCD digit (0..9) that produced it.
- It assembles one 10-bit frame per decade, with bit index equal to the digit, and emits the frame with a one-cycle valid strobe and a popcount.
- It checks that the digit sequence runs 0,1,...,9 and resynchronises on any break.

Parameters:
- FRAME_LEN, 10, digits per frame; the terminal digit is FRAME_LEN-1 (fixed at 10 for BCD; a parameter only for documentation and width derivation).
- CNT_W, 4, width of the digit input and of ones_count.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- sample_en  input  1  qualifies bit_in/digit this cycle; tie to 1 when the upstream counter steps every cycle.
- bit_in  input  1  serial data bit from the upstream mux.
- digit  input  CNT_W  upstream BCD count associated with bit_in.
- frame  output  FRAME_LEN  last completed frame; frame[d] = bit sampled at digit d.
- frame_valid  output  1  one-cycle pulse when frame is updated.
- ones_count  output  CNT_W  number of 1s in frame; updated together with frame.
- seq_err  output  1  one-cycle pulse on a digit-sequence violation.
- locked  output  1  high while in COLLECT state.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: frame=0, ones_count=0, frame_valid=0, seq_err=0, locked=0, state=HUNT, expected digit=0, shadow register=0.
- Reset asserted mid-frame discards the partial frame. Outputs clear immediately, without waiting for a clock edge.
- Sampling: inputs are sampled only at posedge clk with sample_en=1. Cycles with sample_en=0 hold all state, and the pulse outputs go to 0.
- The upstream counter changes on negedge, so bit_in and digit are stable at posedge. The block adds no input synchronisers.

State HUNT:
- Waits for digit==0. On that sample: shadow[0]<=bit_in, expected<=1, go to COLLECT.
- Any other digit value is ignored silently; no seq_err is raised in HUNT.

State COLLECT:
- digit==expected and expected<9: shadow[digit]<=bit_in, expected<=expected+1.
- digit==expected and expected==9: frame<={bit_in, shadow[8:0]}, ones_count<=popcount of that same 10-bit value, frame_valid<=1 next cycle (one cycle wide), expected<=0. Stay in COLLECT, so back-to-back frames need no gap.
- expected==0 in COLLECT: the next sample must be digit 0. It restarts the shadow (shadow[0]<=bit_in, expected<=1).
- digit!=expected: seq_err pulse for one cycle and frame is not updated.
  - If digit==0: treat as a fresh start (shadow[0]<=bit_in, expected<=1, stay in COLLECT).
  - Otherwise: go to HUNT and set expected<=0.
- Non-BCD digit (10..15) in COLLECT is a mismatch and takes the HUNT path.

Other rules:
- locked = (state==COLLECT), registered.
- Latency: the frame appears on the registered outputs one cycle after the posedge that sampled digit 9.
- Widths: ones_count maximum is 10, which fits in 4 bits. No overflow is possible.
- Stale bits: the shadow is not cleared between frames. Every bit is overwritten within a valid frame, so no stale bit can reach frame.

Test Plan:
1. Reset release while digits already run 3,4,...: no frame_valid until the first complete 0..9 pass. locked rises on the sample of digit 0.
2. Upstream decade pattern (bit=1 for digits 0-5, 0 for 6-9), two consecutive decades: two frame_valid pulses exactly 10 cycles apart, each with frame=10'h03F and ones_count=6. seq_err stays 0 throughout.
3. Sequence break 0,1,2,3,5: seq_err pulse after the digit-5 sample, locked drops, no frame. Next 0..9 with all bits=1 gives frame=10'h3FF, ones_count=10.
4. Restart 0,1,2,0,1,...,9 with bits alternating starting at 1 from the second 0: one seq_err, then frame=10'h155, ones_count=5.
5. sample_en=0 for 3 cycles mid-frame (digit held at 4): no error, and the frame completes correctly when sampling resumes at 4.
6. rst_n pulsed low asynchronously between edges at digit 7: all outputs return to 0 immediately. After release with digit 8, the block stays in HUNT until the next digit 0.

Source files
------------

// File: rtl/bcd_frame_deserializer.sv
// Collects one bit per BCD digit into a 10-bit frame. The bit index is the digit.
// It emits each completed frame with a valid strobe and a popcount, and resynchronises on digit-sequence breaks.
module bcd_frame_deserializer #(
  parameter int FRAME_LEN = 10,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_en,
  input  logic                 bit_in,
  input  logic [CNT_W-1:0]     digit,
  output logic [FRAME_LEN-1:0] frame,
  output logic                 frame_valid,
  output logic [CNT_W-1:0]     ones_count,
  output logic                 seq_err,
  output logic                 locked
);

  // state   | meaning
  // HUNT    | waiting for digit 0 to align to a decade
  // COLLECT | aligned; expecting exp_q next, shadow accumulates bits
  typedef enum logic [0:0] {HUNT = 1'b0, COLLECT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       exp_q, exp_d;
  logic [FRAME_LEN-2:0]   shadow_q, shadow_d;
  logic [FRAME_LEN-1:0]   frame_q, frame_d;
  logic [CNT_W-1:0]       ones_q, ones_d;
  logic                   fv_q, fv_d;
  logic                   err_q, err_d;
  logic                   locked_q, locked_d;

  logic [FRAME_LEN-1:0]   cand;
  logic [CNT_W-1:0]       pop;

  always_comb begin
    cand = {bit_in, shadow_q};
    pop  = '0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      pop = pop + CNT_W'(cand[i]);
    end
  end

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    shadow_d = shadow_q;
    frame_d  = frame_q;
    ones_d   = ones_q;
    fv_d     = 1'b0;
    err_d    = 1'b0;

    if (sample_en) begin
      unique case (state_q)
        HUNT: begin
          if (digit == '0) begin
            shadow_d[0] = bit_in;
            exp_d       = CNT_W'(1);
            state_d     = COLLECT;
          end
        end
        COLLECT: begin
          if (digit == exp_q) begin
            if (exp_q == LAST) begin
              frame_d = cand;
              ones_d  = pop;
              fv_d    = 1'b1;
              exp_d   = '0;
            end else begin
              shadow_d[digit] = bit_in;
              exp_d           = exp_q + CNT_W'(1);
            end
          end else begin
            err_d = 1'b1;
            // A stray 0 is itself a valid decade start, so realign without hunting.
            if (digit == '0) begin
              shadow_d[0] = bit_in;
              exp_d       = CNT_W'(1);
            end else begin
              state_d = HUNT;
              exp_d   = '0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    locked_d = (state_d == COLLECT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      exp_q    <= '0;
      shadow_q <= '0;
      frame_q  <= '0;
      ones_q   <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      ones_q   <= ones_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  assign frame       = frame_q;
  assign frame_valid = fv_q;
  assign ones_count  = ones_q;
  assign seq_err     = err_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_bcd_frame_deserializer.sv
// Scoreboard bench for bcd_frame_deserializer: directed scenarios plus a randomized BCD stream.
module tb_bcd_frame_deserializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sample_en;
  logic       bit_in;
  logic [3:0] digit;
  logic [9:0] frame;
  logic       frame_valid;
  logic [3:0] ones_count;
  logic       seq_err;
  logic       locked;

  bcd_frame_deserializer #(.FRAME_LEN(10), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .bit_in(bit_in),
    .digit(digit), .frame(frame), .frame_valid(frame_valid),
    .ones_count(ones_count), .seq_err(seq_err), .locked(locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference: a decade is a run of accepted samples 0..9. run = -1 means not aligned.
  typedef struct { int stamp; logic [9:0] f; logic [3:0] n; } fexp_t;
  fexp_t      fq[$];
  int         eq[$];
  int         run = -1;
  logic [9:0] acc = '0;
  logic       exp_locked = 1'b0;

  task automatic model_reset();
    run = -1;
    exp_locked = 1'b0;
    fq.delete();
    eq.delete();
  endtask

  task automatic model_step(input logic en, input logic [3:0] d, input logic b, input int stamp);
    fexp_t e;
    if (!en) return;
    if (run < 0) begin
      if (d == 0) begin acc[0] = b; run = 1; end
    end else if (int'(d) == run) begin
      acc[d] = b;
      if (d == 9) begin
        e.stamp = stamp; e.f = acc; e.n = 4'($countones(acc));
        fq.push_back(e);
        run = 0;
      end else run++;
    end else begin
      eq.push_back(stamp);
      if (d == 0) begin acc[0] = b; run = 1; end
      else run = -1;
    end
    exp_locked = (run >= 0);
  endtask

  task automatic step(input logic en, input logic [3:0] d, input logic b);
    @(negedge clk);
    sample_en = en; digit = d; bit_in = b;
    if (rst_n) model_step(en, d, b, cyc + 1);
  endtask

  // Monitor: pops expectations whenever the DUT pulses or an event is due this cycle.
  always begin
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (frame_valid || (fq.size() > 0 && fq[0].stamp == cyc)) begin
        if (fq.size() > 0 && fq[0].stamp == cyc) begin
          chk("frame_valid", 32'(frame_valid), 32'd1);
          chk("frame", 32'(frame), 32'(fq[0].f));
          chk("ones_count", 32'(ones_count), 32'(fq[0].n));
          void'(fq.pop_front());
        end else chk("unexpected_frame_valid", 32'(frame_valid), 32'd0);
      end
      if (seq_err || (eq.size() > 0 && eq[0] == cyc)) begin
        if (eq.size() > 0 && eq[0] == cyc) begin
          chk("seq_err", 32'(seq_err), 32'd1);
          void'(eq.pop_front());
        end else chk("unexpected_seq_err", 32'(seq_err), 32'd0);
      end
      chk("locked", 32'(locked), 32'(exp_locked));
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_frame"}, 32'(frame), 32'd0);
    chk({tag, "_ones"}, 32'(ones_count), 32'd0);
    chk({tag, "_fv"}, 32'(frame_valid), 32'd0);
    chk({tag, "_err"}, 32'(seq_err), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
  endtask

  int cur;

  initial begin
    rst_n = 1'b0; sample_en = 1'b1; bit_in = 1'b0; digit = 4'd0;
    #1;
    chk_zero("reset");

    // 1: reset released while the upstream count is already running
    for (int d = 0; d < 3; d++) step(1'b1, 4'(d), 1'b1);
    @(posedge clk); #2 rst_n = 1'b1;
    for (int d = 3; d < 10; d++) step(1'b1, 4'(d), 1'b1);
    chk("hunt_no_lock", 32'(locked), 32'd0);

    // 2: two decades of 1s on digits 0-5
    for (int k = 0; k < 2; k++)
      for (int d = 0; d < 10; d++) step(1'b1, 4'(d), logic'(d < 6));
    @(posedge clk); #1;
    chk("pattern_frame", 32'(frame), 32'h03F);
    chk("pattern_ones", 32'(ones_count), 32'd6);

    // 3: break 0,1,2,3,5 then all ones
    for (int d = 0; d < 4; d++) step(1'b1, 4'(d), 1'b0);
    step(1'b1, 4'd5, 1'b0);
    for (int d = 0; d < 10; d++) step(1'b1, 4'(d), 1'b1);
    @(posedge clk); #1;
    chk("allones_frame", 32'(frame), 32'h3FF);
    chk("allones_ones", 32'(ones_count), 32'd10);

    // 4: restart on a stray 0, alternating bits
    for (int d = 0; d < 3; d++) step(1'b1, 4'(d), 1'b0);
    for (int d = 0; d < 10; d++) step(1'b1, 4'(d), logic'(d % 2 == 0));
    @(posedge clk); #1;
    chk("alt_frame", 32'(frame), 32'h155);
    chk("alt_ones", 32'(ones_count), 32'd5);

    // 5: sampling paused mid-frame with digit held at 4
    for (int d = 0; d < 4; d++) step(1'b1, 4'(d), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 4'd4, 1'b0);
    for (int d = 4; d < 10; d++) step(1'b1, 4'(d), logic'(d > 6));

    // 6: asynchronous reset between edges at digit 7
    for (int d = 0; d < 8; d++) step(1'b1, 4'(d), 1'b1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    model_reset();
    #1 rst_n = 1'b1;
    step(1'b1, 4'd8, 1'b1);
    step(1'b1, 4'd9, 1'b1);
    @(posedge clk); #1;
    chk("post_rst_hunt", 32'(locked), 32'd0);
    for (int d = 0; d < 10; d++) step(1'b1, 4'(d), logic'(d[0]));

    // Randomized upstream counter with occasional jumps and sampling gaps
    cur = 0;
    for (int i = 0; i < 1500; i++) begin
      logic en;
      en = ($urandom_range(0, 7) != 0);
      step(en, 4'(cur), logic'($urandom_range(0, 1)));
      if (en) begin
        if ($urandom_range(0, 24) == 0) cur = $urandom_range(0, 15);
        else cur = (cur >= 9) ? 0 : cur + 1;
      end
    end

    step(1'b0, 4'd0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk("frames_drained", 32'(fq.size()), 32'd0);
    chk("errors_drained", 32'(eq.size()), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
